// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory access path.
//   SZ_*          : access size encodings on req_size
//   state_t       : access controller state encoding
//   req_t         : registered request payload
//   MEM_BYTES_DEF : default data memory size in bytes
package mem_pkg;

  localparam int unsigned MEM_BYTES_DEF = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } req_t;

  // Number of bytes touched by an access of the given size encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering between a 32-bit memory word and a sub-word access.
//   size, offset : access size encoding and byte offset within the word
//   is_unsigned  : zero-extend (1) or sign-extend (0) sub-word loads
//   word         : word read from memory
//   wdata        : right-justified store data
//   load_c       : extended load result
//   merge_c      : word with the addressed lane replaced by store data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_c,
  output logic [31:0] merge_c
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) bytes.
  always_comb begin
    byte_sh   = {~offset, 3'b000};
    half_sh   = {~offset[1], 4'b0000};
    byte_lane = 8'(word >> byte_sh);
    half_lane = 16'(word >> half_sh);
    load_c    = word;
    merge_c   = wdata;
    case (size)
      SZ_BYTE: begin
        load_c  = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merge_c = (word & ~(32'h0000_00FF << byte_sh)) | (32'(wdata[7:0]) << byte_sh);
      end
      SZ_HALF: begin
        load_c  = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merge_c = (word & ~(32'h0000_FFFF << half_sh)) | (32'(wdata[15:0]) << half_sh);
      end
      default: begin
        load_c  = word;
        merge_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller driving a big-endian, byte-addressed data memory.
//   req/req_*      : pipeline request, held until done
//   stall          : hold pipeline while a request is outstanding
//   done/rdata/err : one-cycle completion with extended load data and error flag
//   mem_*          : word-aligned memory port (read data returns combinationally)
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_out32
);

  state_t      state_q;
  state_t      state_d;
  req_t        req_q;
  logic        bad_c;
  logic [31:0] load_c;
  logic [31:0] merge_c;

  mem_lane_align u_align (
    .size        (req_q.size),
    .offset      (req_q.offset),
    .is_unsigned (req_q.uns),
    .word        (mem_out32),
    .wdata       (req_q.wdata),
    .load_c      (load_c),
    .merge_c     (merge_c)
  );

  // Reset gating keeps the pipeline moving while the controller is held in reset.
  assign stall = rst_n & req & ~done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request classification, next state and memory enables decoded from state.
  always_comb begin
    state_d      = state_q;
    bad_c        = 1'b0;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;

    case (req_size)
      SZ_BYTE: bad_c = 1'b0;
      SZ_HALF: bad_c = req_addr[0];
      SZ_WORD: bad_c = |req_addr[1:0];
      default: bad_c = 1'b1;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    if (({1'b0, req_addr} + 33'(size_bytes(req_size))) > 33'(MEM_BYTES)) bad_c = 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (bad_c)                 state_d = RESP;
          else if (!req_we)          state_d = LOAD;
          else if (req_size == SZ_WORD) state_d = STORE;
          else                       state_d = RMW_RD;
        end
      end
      LOAD: begin
        mem_memread = 1'b1;
        state_d     = RESP;
      end
      STORE: begin
        mem_memwrite = 1'b1;
        state_d      = RESP;
      end
      RMW_RD: begin
        mem_memread = 1'b1;
        state_d     = RMW_WR;
      end
      RMW_WR: begin
        mem_memwrite = 1'b1;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load result and store word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q         <= '0;
      mem_address   <= '0;
      mem_writeData <= '0;
      rdata         <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= (state_d == RESP);
      err  <= (state_q == IDLE) && req && bad_c;
      case (state_q)
        IDLE: begin
          if (req) begin
            req_q.size    <= req_size;
            req_q.uns     <= req_unsigned;
            req_q.offset  <= req_addr[1:0];
            req_q.wdata   <= req_wdata;
            mem_address   <= {req_addr[31:2], 2'b00};
            mem_writeData <= req_wdata;
            rdata         <= '0;
          end
        end
        LOAD:    rdata         <= load_c;
        RMW_RD:  mem_writeData <= merge_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a 256-byte big-endian memory model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err, mem_memwrite, mem_memread;
  logic [31:0] rdata, mem_address, mem_writeData, mem_out32;

  logic [7:0]  mem [0:255];
  bit          init_mem;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int          checks = 0, errors = 0;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_lat;
    logic        exp_err;
    logic [1:0]  exp_nrd;
    logic [1:0]  exp_nwr;
    logic        keep;
  } vec_t;

  mem_access_ctrl #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_out32(mem_out32)
  );

  always #5 clk = ~clk;

  assign mem_out32 = {mem[{mem_address[7:2], 2'd0}], mem[{mem_address[7:2], 2'd1}],
                      mem[{mem_address[7:2], 2'd2}], mem[{mem_address[7:2], 2'd3}]};

  // Memory model: preload during the first reset, then word writes on memwrite.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[4] <= 8'hFF; mem[5] <= 8'hFF; mem[6] <= 8'hFF; mem[7] <= 8'hFF;
      mem[12] <= 8'h7F; mem[13] <= 8'h80; mem[14] <= 8'h01; mem[15] <= 8'h02;
      mem[16] <= 8'hAA; mem[17] <= 8'hBB; mem[18] <= 8'hCC; mem[19] <= 8'hDD;
    end else if (mem_memwrite) begin
      mem[{mem_address[7:2], 2'd0}] <= mem_writeData[31:24];
      mem[{mem_address[7:2], 2'd1}] <= mem_writeData[23:16];
      mem[{mem_address[7:2], 2'd2}] <= mem_writeData[15:8];
      mem[{mem_address[7:2], 2'd3}] <= mem_writeData[7:0];
    end
    if (mem_memread)                 rd_cnt   <= rd_cnt + 1;
    if (mem_memwrite)                wr_cnt   <= wr_cnt + 1;
    if (mem_memread && mem_memwrite) both_cnt <= both_cnt + 1;
  end

  // Present one request at a negedge and count posedges until done (99 = timeout).
  task automatic run_access(input vec_t v, output int lat, output logic [31:0] rd,
                            output logic e, output bit stall_bad, output int nrd, output int nwr);
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_we = v.we; req_size = v.sz; req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wd;
    req = 1'b1;
    lat = 99; rd = 'x; e = 1'bx; stall_bad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k; rd = rdata; e = err;
        if (stall !== 1'b0) stall_bad = 1'b1;
        break;
      end else if (stall !== 1'b1) stall_bad = 1'b1;
    end
    nrd = rd_cnt - rd0; nwr = wr_cnt - wr0;
    if (!v.keep || lat == 99) req = 1'b0;
  endtask

  task automatic test_reset();
    req = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if ({mem_memread, mem_memwrite} !== 2'b00) begin errors++; $display("FAIL reset_enables got %b want 00", {mem_memread, mem_memwrite}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_address got %h want 0", mem_address); end
    checks++; if (mem_writeData !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_writeData); end
    req = 1'b0;
  endtask

  task automatic test_loads();
    vec_t v [10] = '{
      '{1'b0, SZ_BYTE, 1'b0, 32'd5,  32'h0, 32'hFFFF_FFFF, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_BYTE, 1'b1, 32'd5,  32'h0, 32'h0000_00FF, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_HALF, 1'b1, 32'd6,  32'h0, 32'h0000_FFFF, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_HALF, 1'b0, 32'd4,  32'h0, 32'hFFFF_FFFF, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_BYTE, 1'b0, 32'd13, 32'h0, 32'hFFFF_FF80, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_BYTE, 1'b1, 32'd13, 32'h0, 32'h0000_0080, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_HALF, 1'b0, 32'd14, 32'h0, 32'h0000_0102, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'd12, 32'h0, 32'h7F80_0102, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_BYTE, 1'b0, 32'd12, 32'h0, 32'h0000_007F, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_HALF, 1'b0, 32'd12, 32'h0, 32'h0000_7F80, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0}
    };
    int lat, nrd, nwr; logic [31:0] rd; logic e; bit sb;
    foreach (v[i]) begin
      run_access(v[i], lat, rd, e, sb, nrd, nwr);
      checks++; if (lat !== 32'(v[i].exp_lat)) begin errors++; $display("FAIL load%0d_latency got %0d want %0d", i, lat, v[i].exp_lat); end
      checks++; if (rd !== v[i].exp_rd) begin errors++; $display("FAIL load%0d_rdata got %h want %h", i, rd, v[i].exp_rd); end
      checks++; if (e !== v[i].exp_err) begin errors++; $display("FAIL load%0d_err got %b want %b", i, e, v[i].exp_err); end
      checks++; if (sb) begin errors++; $display("FAIL load%0d_stall got wrong stall want req&&!done", i); end
      checks++; if (nrd != 32'(v[i].exp_nrd) || nwr != 32'(v[i].exp_nwr)) begin errors++; $display("FAIL load%0d_enables got rd=%0d wr=%0d want rd=%0d wr=%0d", i, nrd, nwr, v[i].exp_nrd, v[i].exp_nwr); end
      @(negedge clk);
    end
  endtask

  task automatic test_stores();
    vec_t v [10] = '{
      '{1'b1, SZ_BYTE, 1'b0, 32'd9,   32'h0000_0012, 32'h0,          4'd3, 1'b0, 2'd1, 2'd1, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'd8,   32'h0,         32'h0012_0000, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b1, SZ_HALF, 1'b0, 32'd10,  32'h1234_BEEF, 32'h0,          4'd3, 1'b0, 2'd1, 2'd1, 1'b0},
      '{1'b1, SZ_BYTE, 1'b0, 32'd11,  32'hFFFF_FF34, 32'h0,          4'd3, 1'b0, 2'd1, 2'd1, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'd8,   32'h0,         32'h0012_BE34, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b1, SZ_WORD, 1'b0, 32'd252, 32'h1111_1111, 32'h0,          4'd2, 1'b0, 2'd0, 2'd1, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'd252, 32'h0,         32'h1111_1111, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_BYTE, 1'b0, 32'd255, 32'h0,         32'h0000_0011, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b0, SZ_HALF, 1'b0, 32'd254, 32'h0,         32'h0000_1111, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0},
      '{1'b1, SZ_WORD, 1'b0, 32'd254, 32'h2222_2222, 32'h0,          4'd1, 1'b1, 2'd0, 2'd0, 1'b0}
    };
    int lat, nrd, nwr; logic [31:0] rd; logic e; bit sb;
    foreach (v[i]) begin
      run_access(v[i], lat, rd, e, sb, nrd, nwr);
      checks++; if (lat !== 32'(v[i].exp_lat)) begin errors++; $display("FAIL store%0d_latency got %0d want %0d", i, lat, v[i].exp_lat); end
      checks++; if (rd !== v[i].exp_rd) begin errors++; $display("FAIL store%0d_rdata got %h want %h", i, rd, v[i].exp_rd); end
      checks++; if (e !== v[i].exp_err) begin errors++; $display("FAIL store%0d_err got %b want %b", i, e, v[i].exp_err); end
      checks++; if (sb) begin errors++; $display("FAIL store%0d_stall got wrong stall want req&&!done", i); end
      checks++; if (nrd != 32'(v[i].exp_nrd) || nwr != 32'(v[i].exp_nwr)) begin errors++; $display("FAIL store%0d_enables got rd=%0d wr=%0d want rd=%0d wr=%0d", i, nrd, nwr, v[i].exp_nrd, v[i].exp_nwr); end
      @(negedge clk);
    end
    checks++; if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h0012_BE34) begin errors++; $display("FAIL mem_word8 got %h want 0012be34", {mem[8], mem[9], mem[10], mem[11]}); end
    checks++; if ({mem[252], mem[253], mem[254], mem[255]} !== 32'h1111_1111) begin errors++; $display("FAIL mem_word252 got %h want 11111111", {mem[252], mem[253], mem[254], mem[255]}); end
  endtask

  task automatic test_errors();
    vec_t v [5] = '{
      '{1'b1, SZ_HALF, 1'b0, 32'd5,   32'hDEAD_BEEF, 32'h0, 4'd1, 1'b1, 2'd0, 2'd0, 1'b0},
      '{1'b0, SZ_WORD, 1'b0, 32'd258, 32'h0,         32'h0, 4'd1, 1'b1, 2'd0, 2'd0, 1'b0},
      '{1'b0, 2'b11,   1'b0, 32'd0,   32'h0,         32'h0, 4'd1, 1'b1, 2'd0, 2'd0, 1'b0},
      '{1'b0, SZ_HALF, 1'b1, 32'd255, 32'h0,         32'h0, 4'd1, 1'b1, 2'd0, 2'd0, 1'b0},
      '{1'b1, SZ_BYTE, 1'b0, 32'd256, 32'h0000_0055, 32'h0, 4'd1, 1'b1, 2'd0, 2'd0, 1'b0}
    };
    int lat, nrd, nwr; logic [31:0] rd; logic e; bit sb;
    // Leave a nonzero rdata behind so the error path has to clear it.
    vec_t pre = '{1'b0, SZ_WORD, 1'b0, 32'd4, 32'h0, 32'hFFFF_FFFF, 4'd2, 1'b0, 2'd1, 2'd0, 1'b0};
    run_access(pre, lat, rd, e, sb, nrd, nwr);
    @(negedge clk);
    foreach (v[i]) begin
      run_access(v[i], lat, rd, e, sb, nrd, nwr);
      checks++; if (lat !== 32'(v[i].exp_lat)) begin errors++; $display("FAIL err%0d_latency got %0d want %0d", i, lat, v[i].exp_lat); end
      checks++; if (rd !== v[i].exp_rd) begin errors++; $display("FAIL err%0d_rdata got %h want %h", i, rd, v[i].exp_rd); end
      checks++; if (e !== v[i].exp_err) begin errors++; $display("FAIL err%0d_err got %b want %b", i, e, v[i].exp_err); end
      checks++; if (nrd != 0 || nwr != 0) begin errors++; $display("FAIL err%0d_enables got rd=%0d wr=%0d want rd=0 wr=0", i, nrd, nwr); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int wr0;
    req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0; req_addr = 32'd17; req_wdata = 32'h0000_0055;
    req = 1'b1;
    @(negedge clk);
    checks++; if (mem_memread !== 1'b1) begin errors++; $display("FAIL rmw_rd_enable got %b want 1", mem_memread); end
    @(negedge clk);
    checks++; if (mem_memwrite !== 1'b1) begin errors++; $display("FAIL rmw_wr_enable got %b want 1", mem_memwrite); end
    checks++; if (mem_writeData !== 32'hAA55_CCDD) begin errors++; $display("FAIL rmw_merge got %h want aa55ccdd", mem_writeData); end
    wr0 = wr_cnt;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({mem_memread, mem_memwrite} !== 2'b00) begin errors++; $display("FAIL rst_enables got %b want 00", {mem_memread, mem_memwrite}); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_stall_done got %b%b want 00", stall, done); end
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    checks++; if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hAABB_CCDD || wr_cnt != wr0) begin errors++; $display("FAIL rst_no_write got %h writes=%0d want aabbccdd writes=0", {mem[16], mem[17], mem[18], mem[19]}, wr_cnt - wr0); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_no_done%0d got %b want 0", k, done); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [3] = '{
      '{1'b0, SZ_BYTE, 1'b0, 32'd5,  32'h0,         32'hFFFF_FFFF, 4'd2, 1'b0, 2'd1, 2'd0, 1'b1},
      '{1'b1, SZ_WORD, 1'b0, 32'd20, 32'hCAFE_F00D, 32'h0,          4'd3, 1'b0, 2'd0, 2'd1, 1'b1},
      '{1'b0, SZ_HALF, 1'b0, 32'd22, 32'h0,         32'hFFFF_F00D, 4'd3, 1'b0, 2'd1, 2'd0, 1'b0}
    };
    int lat, nrd, nwr; logic [31:0] rd; logic e; bit sb;
    foreach (v[i]) begin
      run_access(v[i], lat, rd, e, sb, nrd, nwr);
      checks++; if (lat !== 32'(v[i].exp_lat)) begin errors++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, v[i].exp_lat); end
      checks++; if (rd !== v[i].exp_rd) begin errors++; $display("FAIL b2b%0d_rdata got %h want %h", i, rd, v[i].exp_rd); end
      checks++; if (e !== v[i].exp_err) begin errors++; $display("FAIL b2b%0d_err got %b want %b", i, e, v[i].exp_err); end
      checks++; if (sb) begin errors++; $display("FAIL b2b%0d_stall got wrong stall want req&&!done", i); end
      checks++; if (nrd != 32'(v[i].exp_nrd) || nwr != 32'(v[i].exp_nwr)) begin errors++; $display("FAIL b2b%0d_enables got rd=%0d wr=%0d want rd=%0d wr=%0d", i, nrd, nwr, v[i].exp_nrd, v[i].exp_nwr); end
    end
    @(negedge clk);
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL enables_exclusive got %0d overlaps want 0", both_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; init_mem = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    init_mem = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
